// File: rtl/vec_mmio_pkg.sv
// vec_mmio_pkg: address map, geometry and FSM state type for the vector-to-scalar bridge.
package vec_mmio_pkg;
  localparam logic [15:0] CMD_ADDR    = 16'd265;
  localparam logic [15:0] STATUS_ADDR = 16'd266;
  localparam logic [15:0] LANE_BASE   = 16'd272;
  localparam int LANES    = 8;
  localparam int LANE_W   = 32;
  localparam int VEC_W    = 256;
  localparam int NUM_VECS = 3;
  localparam int TIMEOUT  = 15;
  localparam int TMO_W    = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, REQ, DONE} split_state_t;
endpackage

// File: rtl/vec_lane_mux.sv
// vec_lane_mux: selects one 32-bit lane out of the captured 256-bit vector.
module vec_lane_mux
  import vec_mmio_pkg::*;
(
  input  logic [VEC_W-1:0]  vec,
  input  logic [2:0]        sel,
  output logic [LANE_W-1:0] lane
);
  assign lane = vec[sel*LANE_W +: LANE_W];
endmodule

// File: rtl/vec_splitter.sv
// vec_splitter: fetches a vector on a CMD write and exposes it as read-only scalar lanes plus status.
module vec_splitter
  import vec_mmio_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       addr,
  input  logic              memWrite,
  input  logic [31:0]       wrData,
  output logic [31:0]       rdData,
  output logic              rdHit,
  output logic [15:0]       vecAddr,
  output logic              vecRdReq,
  input  logic              vecRdAck,
  input  logic [VEC_W-1:0]  vecData,
  output logic              busy
);
  split_state_t state, nstate;
  logic [TMO_W-1:0] tmo_cnt;
  logic [VEC_W-1:0] buffer;
  logic [LANE_W-1:0] lane;
  logic wr_cmd, wr_stat, idx_ok, start, tmo_last, lane_hit;
  logic valid, err_idx, err_tmo, err_ovr;
  assign wr_cmd   = memWrite && addr == CMD_ADDR;
  assign wr_stat  = memWrite && addr == STATUS_ADDR;
  assign idx_ok   = wrData < 32'(NUM_VECS);
  assign start    = state != REQ && wr_cmd && idx_ok;
  assign tmo_last = tmo_cnt == TMO_W'(TIMEOUT - 1);
  assign lane_hit = addr >= LANE_BASE && addr < LANE_BASE + 16'(LANES);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nstate;
  always_comb
    nstate = state == REQ ? (vecRdAck ? DONE : tmo_last ? IDLE : REQ) : start ? REQ : state;
  always_comb begin
    busy     = state == REQ;
    vecRdReq = state == REQ;
  end
  // Error bits: a set on the same edge as a STATUS write takes priority over the clear.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vecAddr <= '0;
      buffer  <= '0;
      tmo_cnt <= '0;
      valid   <= 1'b0;
      err_idx <= 1'b0;
      err_tmo <= 1'b0;
      err_ovr <= 1'b0;
    end else begin
      if (start) begin
        vecAddr <= wrData[15:0];
        valid   <= 1'b0;
        tmo_cnt <= '0;
      end
      if (busy && vecRdAck) begin
        buffer <= vecData;
        valid  <= 1'b1;
      end
      if (busy && !vecRdAck) tmo_cnt <= tmo_cnt + 1'b1;
      err_idx <= (state != REQ && wr_cmd && !idx_ok) || (err_idx && !wr_stat);
      err_tmo <= (busy && !vecRdAck && tmo_last) || (err_tmo && !wr_stat);
      err_ovr <= (busy && wr_cmd) || (err_ovr && !wr_stat);
    end
  vec_lane_mux u_mux (
    .vec  (buffer),
    .sel  (3'(addr - LANE_BASE)),
    .lane (lane)
  );
  assign rdHit = addr == CMD_ADDR || addr == STATUS_ADDR || lane_hit;
  always_comb
    rdData = addr == CMD_ADDR    ? {16'b0, vecAddr} :
             addr == STATUS_ADDR ? {27'b0, err_ovr, err_tmo, err_idx, valid, busy} :
             lane_hit            ? lane : '0;
endmodule

// File: tb/tb_vec_splitter.sv
// tb_vec_splitter: directed stimulus with a queued scoreboard checked by an independent monitor.
module tb_vec_splitter;
  logic clk = 0, rst_n = 0, memWrite = 0, vecRdAck = 0, rd_en = 0;
  logic [15:0] addr = '0;
  logic [31:0] wrData = '0;
  logic [255:0] vecData = '0;
  logic [31:0] rdData;
  logic rdHit, vecRdReq, busy;
  logic [15:0] vecAddr;
  int checks = 0, failures = 0;
  typedef struct {string nm; logic [31:0] rd; logic hit; logic req;} exp_t;
  exp_t q[$];
  localparam logic [15:0] CMD = 16'd265, STS = 16'd266, LB = 16'd272;
  vec_splitter dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .memWrite(memWrite), .wrData(wrData),
    .rdData(rdData), .rdHit(rdHit), .vecAddr(vecAddr), .vecRdReq(vecRdReq),
    .vecRdAck(vecRdAck), .vecData(vecData), .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic logic [255:0] pat(input logic [31:0] b);
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = b + 32'(i);
    return v;
  endfunction
  always begin
    @(negedge clk);
    #2;
    if (rd_en) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_underflow actual=empty required=entry");
      end else begin
        exp_t e;
        e = q.pop_front();
        if (rdData !== e.rd) begin
          failures++;
          $display("FAIL %s rdData actual=%h required=%h", e.nm, rdData, e.rd);
        end
        checks++;
        if (rdHit !== e.hit) begin
          failures++;
          $display("FAIL %s rdHit actual=%b required=%b", e.nm, rdHit, e.hit);
        end
        checks++;
        if (vecRdReq !== e.req || busy !== e.req) begin
          failures++;
          $display("FAIL %s req/busy actual=%b/%b required=%b", e.nm, vecRdReq, busy, e.req);
        end
      end
    end
  end
  task automatic step(input logic [15:0] a, input logic we, input logic [31:0] d,
                      input logic ack, input logic [255:0] vd);
    @(negedge clk);
    addr = a; memWrite = we; wrData = d; vecRdAck = ack; vecData = vd; rd_en = 0;
  endtask
  task automatic chk(input string nm, input logic [15:0] a, input logic [31:0] rd,
                     input logic hit, input logic req);
    @(negedge clk);
    addr = a; memWrite = 0; wrData = '0; vecRdAck = 0; vecData = '0; rd_en = 1;
    q.push_back('{nm, rd, hit, req});
  endtask
  initial begin
    chk("rst_status", STS, 32'h0, 1, 0);
    chk("rst_cmd", CMD, 32'h0, 1, 0);
    chk("rst_lane0", LB, 32'h0, 1, 0);
    @(negedge clk); rst_n = 1; rd_en = 0;
    step(CMD, 1, 32'd1, 0, '0);
    chk("t1_req", STS, 32'h01, 1, 1);
    @(negedge clk);
    rst_n = 0; addr = STS; memWrite = 0; rd_en = 1;
    q.push_back('{"t1_async_rst", 32'h0, 1'b1, 1'b0});
    chk("t1_rst_cmd", CMD, 32'h0, 1, 0);
    @(negedge clk); rst_n = 1; rd_en = 0;
    step(16'd0, 0, 32'd0, 1, pat(32'hA0));
    chk("t1_late_ack_lane", LB, 32'h0, 1, 0);
    chk("t1_late_ack_sts", STS, 32'h0, 1, 0);
    step(CMD, 1, 32'd5, 0, '0);
    chk("t3_bad_idx", STS, 32'h04, 1, 0);
    step(STS, 1, 32'hFFFF, 0, '0);
    chk("t3_clear", STS, 32'h00, 1, 0);
    step(CMD, 1, 32'd1, 0, '0);
    chk("t2_wait1", STS, 32'h01, 1, 1);
    step(16'd0, 0, 32'd0, 0, '0);
    step(16'd0, 0, 32'd0, 1, pat(32'hA0));
    chk("t2_vecaddr", CMD, 32'h1, 1, 0);
    for (int i = 0; i < 8; i++) chk($sformatf("t2_lane%0d", i), LB + 16'(i), 32'hA0 + 32'(i), 1, 0);
    chk("t2_status", STS, 32'h02, 1, 0);
    step(CMD, 1, 32'd0, 0, '0);
    for (int j = 0; j < 16; j++)
      chk($sformatf("t4_tmo%0d", j), STS, j < 15 ? 32'h01 : 32'h08, 1, j < 15);
    chk("t4_lane_kept", LB, 32'hA0, 1, 0);
    chk("t4_vecaddr", CMD, 32'h0, 1, 0);
    step(STS, 1, 32'd0, 0, '0);
    chk("t5_clear", STS, 32'h00, 1, 0);
    step(CMD, 1, 32'd1, 0, '0);
    step(CMD, 1, 32'd2, 1, pat(32'hB0));
    chk("t5_status", STS, 32'h12, 1, 0);
    chk("t5_vecaddr", CMD, 32'h1, 1, 0);
    chk("t5_lane3", LB + 16'd3, 32'hB3, 1, 0);
    step(LB + 16'd1, 1, 32'hDEAD, 0, '0);
    step(16'd300, 1, 32'hBEEF, 0, '0);
    chk("t6_lane1", LB + 16'd1, 32'hB1, 1, 0);
    chk("t6_addr300", 16'd300, 32'h0, 0, 0);
    chk("t6_addr271", 16'd271, 32'h0, 0, 0);
    chk("t6_addr280", 16'd280, 32'h0, 0, 0);
    chk("t6_lane7", LB + 16'd7, 32'hB7, 1, 0);
    @(negedge clk); rd_en = 0;
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover actual=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
